// File: rtl/sha256_mem_arbiter_if.sv
// Requester/memory bus shared by the SHA-256 engines and the single memory port.
// The arbiter sits on the slave modport and the requesters/memory on the master modport.
interface sha256_mem_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*16-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [2:0]            owner;
  logic                  busy;
  logic                  hold_expired;
  logic                  memory_clk;
  logic [15:0]           memory_addr;
  logic                  enable_write;
  logic [31:0]           memory_write_data;
  logic [31:0]           memory_read_data;
  logic [31:0]           rd_data;

  modport slave (
    input  req, req_addr, req_we, req_wdata, memory_read_data,
    output gnt, owner, busy, hold_expired, memory_clk, memory_addr,
           enable_write, memory_write_data, rd_data
  );

  modport master (
    output req, req_addr, req_we, req_wdata, memory_read_data,
    input  gnt, owner, busy, hold_expired, memory_clk, memory_addr,
           enable_write, memory_write_data, rd_data
  );
endinterface

// File: rtl/sha256_mem_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters exclusive use of one memory port.
// Define SHA_ARB_HOLD_LIMIT_EN to revoke grants held longer than MAX_HOLD cycles.
module sha256_mem_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sha256_mem_arbiter_if.slave  bus
);
  typedef enum logic {ARB, OWN} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] gnt_q;
  logic [2:0]         owner_q;
  logic [2:0]         rr_ptr;
  logic [2:0]         winner;
  logic [2:0]         next_ptr;
  logic               found;
  logic               owner_req;
  logic               expired;
  logic [15:0]        mux_addr;
  logic               mux_we;
  logic [31:0]        mux_wdata;

`ifdef SHA_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_cnt;
`endif

  // Two passes: indices at/after rr_ptr first, then wrap to the bottom.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && bus.req[i] && 3'(i) >= rr_ptr) begin
        found  = 1'b1;
        winner = 3'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && bus.req[i]) begin
        found  = 1'b1;
        winner = 3'(i);
      end
  end

  assign next_ptr  = (winner == 3'(NUM_REQ-1)) ? 3'd0 : winner + 3'd1;
  assign owner_req = |(bus.req & gnt_q);

  // gnt is one-hot in OWN and zero in ARB, so an AND-OR mux isolates the owner.
  always_comb begin
    mux_addr  = '0;
    mux_we    = 1'b0;
    mux_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_q[i]) begin
        mux_addr  = mux_addr  | bus.req_addr[16*i +: 16];
        mux_we    = mux_we    | bus.req_we[i];
        mux_wdata = mux_wdata | bus.req_wdata[32*i +: 32];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_ptr  <= '0;
`ifdef SHA_ARB_HOLD_LIMIT_EN
      expired  <= 1'b0;
      hold_cnt <= '0;
`endif
    end else begin
`ifdef SHA_ARB_HOLD_LIMIT_EN
      expired <= 1'b0;
`endif
      case (state)
        ARB: if (found) begin
          state   <= OWN;
          gnt_q   <= NUM_REQ'(1) << winner;
          owner_q <= winner;
          rr_ptr  <= next_ptr;
`ifdef SHA_ARB_HOLD_LIMIT_EN
          hold_cnt <= '0;
`endif
        end
        OWN: begin
          if (!owner_req) begin
            state   <= ARB;
            gnt_q   <= '0;
            owner_q <= '0;
          end
`ifdef SHA_ARB_HOLD_LIMIT_EN
          else if (hold_cnt == HW'(MAX_HOLD-1)) begin
            state   <= ARB;
            gnt_q   <= '0;
            owner_q <= '0;
            expired <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: state <= ARB;
      endcase
    end
  end

`ifndef SHA_ARB_HOLD_LIMIT_EN
  assign expired = 1'b0;
`endif

  assign bus.gnt               = gnt_q;
  assign bus.owner             = owner_q;
  assign bus.busy              = (state == OWN);
  assign bus.hold_expired      = expired;
  assign bus.memory_clk        = clk;
  assign bus.memory_addr       = mux_addr;
  assign bus.enable_write      = mux_we;
  assign bus.memory_write_data = mux_wdata;
  assign bus.rd_data           = bus.memory_read_data;
endmodule

// File: doc/sha256_mem_arbiter.md
SHA256_MEM_ARBITER -- requirements
Module: sha256_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one memory port; legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 64, maximum grant length in cycles when the hold limit is compiled in; legal range 2..1024.
REQ-003 clk  in  1  single clock, all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req  in  NUM_REQ  per-requester bus request, level-held for the whole access.
REQ-006 req_addr  in  NUM_REQ*16  packed word addresses; requester i occupies bits [16i+15:16i].
REQ-007 req_we  in  NUM_REQ  per-requester write enable.
REQ-008 req_wdata  in  NUM_REQ*32  packed write data; requester i occupies bits [32i+31:32i].
REQ-009 gnt  out  NUM_REQ  one-hot grant, registered.
REQ-010 owner  out  3  index of the current grant holder; 0 when idle.
REQ-011 busy  out  1  high while any grant is held.
REQ-012 hold_expired  out  1  one-cycle pulse when a grant is revoked by the hold limit.
REQ-013 memory_clk  out  1  equals clk.
REQ-014 memory_addr  out  16  address driven to memory.
REQ-015 enable_write  out  1  memory write strobe.
REQ-016 memory_write_data  out  32  data driven to memory.
REQ-017 memory_read_data  in  32  memory read data, valid one cycle after the address.
REQ-018 rd_data  out  32  memory_read_data broadcast to all requesters, combinational.

Function
REQ-019 The FSM SHALL have exactly two states, ARB and OWN; reset state is ARB.
REQ-020 In ARB with any req bit high, the arbiter SHALL select the lowest index at or after rr_ptr, wrapping modulo NUM_REQ; set gnt and owner to the winner and move to OWN on the next edge.
REQ-021 On every grant, rr_ptr SHALL become (winner+1) mod NUM_REQ, so NUM_REQ-1 wraps to 0.
REQ-022 In ARB with req all zero, the arbiter SHALL stay in ARB with gnt=0 and rr_ptr unchanged.
REQ-023 In OWN, memory_addr, enable_write and memory_write_data SHALL be combinational muxes of the owner's req_addr, req_we and req_wdata.
REQ-024 Non-owner req_we SHALL never reach enable_write.
REQ-025 In ARB, memory_addr SHALL be 0, enable_write 0 and memory_write_data 0.
REQ-026 In OWN, when req[owner] is low, gnt SHALL clear and the FSM SHALL return to ARB on that edge; there is one mandatory turnaround cycle in ARB between consecutive grants.
REQ-027 Same-cycle release and new requests SHALL be granted only after the ARB turnaround cycle.
REQ-028 Grant latency from req rising (bus free) SHALL be exactly 1 cycle; worst case is (NUM_REQ-1) full grants plus turnarounds.
REQ-029 A req that drops before being sampled in ARB SHALL receive no grant.
REQ-030 busy SHALL equal (state==OWN).
REQ-031 gnt SHALL have at most one bit set at all times.

Reset
REQ-032 With rst high at a rising edge, the block SHALL enter ARB with: gnt=0, owner=0, busy=0, hold_expired=0, rr_ptr=0, hold counter=0.
REQ-033 Reset asserted mid-grant SHALL drop the grant on that edge, and enable_write SHALL be 0 from the following cycle.

Configuration
REQ-034 Macro SHA_ARB_HOLD_LIMIT_EN, when defined, SHALL compile in a hold counter that is cleared on grant and increments each OWN cycle.
REQ-035 With SHA_ARB_HOLD_LIMIT_EN defined: when the counter reaches MAX_HOLD-1, the block SHALL revoke the grant on the next edge, pulse hold_expired for 1 cycle and enter ARB, even if req[owner] is still high.
REQ-036 With SHA_ARB_HOLD_LIMIT_EN undefined, no counter SHALL exist, grants SHALL be held indefinitely and hold_expired SHALL be tied 0.

Verification
REQ-037 Reset, then req=4'b0001 with addr 0x0010, we=0 -> gnt=0001 after 1 cycle, memory_addr=0x0010, rd_data follows memory one cycle later.
REQ-038 req=4'b1111 held, each owner releasing after 3 cycles -> grant order 0,1,2,3,0, each grant separated by one ARB cycle.
REQ-039 Owner 2 writes 0xDEADBEEF at 0x0100 while req 0 asserts we=1 at 0x0000 -> only address 0x0100 is written.
REQ-040 rst pulsed while owner 1 is writing -> gnt=0 and enable_write=0 the next cycle, rr_ptr=0 afterwards.
REQ-041 Hold limit enabled, MAX_HOLD=8, req[0] held high -> grant revoked after 8 OWN cycles, hold_expired pulses once, req 0 is regranted only if no other requester is pending.
REQ-042 Hold limit disabled, req[3] held for 2000 cycles -> gnt=1000 throughout and hold_expired stays 0.
